// File: rtl/daq_axis_pkg.sv
// Shared types and helpers for the DAQ AXI-Stream frame receiver.
package daq_axis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    localparam int CNT_W = 16;

    // Pointer width for a FIFO of the given depth: one extra MSB for wrap.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous-read port.
module sdp_ram #(
    parameter int W     = 33,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // The read register doubles as the stream output stage, so it is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_frame_rx.sv
// Store-and-forward AXI-Stream frame receiver with length check and rollback.
// Define AXIS_FRAME_RX_TUSER_EN to carry first-beat tuser per frame to m_tuser.
module axis_frame_rx
    import daq_axis_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int USER_W  = 8,
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic [USER_W-1:0] s_tuser,
    input  logic [LEN_W-1:0]  exp_len,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [USER_W-1:0] m_tuser,
    output logic [CNT_W-1:0]  frame_ok_cnt,
    output logic [CNT_W-1:0]  frame_err_cnt,
    output rx_state_e         dbg_state
);

    localparam int AW = ptr_w(DEPTH);
    localparam int RW = DATA_W + 1;

    rx_state_e        r_state, w_state_nxt;
    logic [AW-1:0]    r_wr_ptr, r_cm_ptr, r_rd_ptr, r_ra_ptr;
    logic [AW-1:0]    w_wr_nxt, w_cm_nxt, w_rd_nxt;
    logic [LEN_W-1:0] r_beat_cnt, w_beat_nxt, r_exp_len, w_exp_cur, w_cnt1;
    logic [CNT_W-1:0] r_ok_cnt, r_err_cnt;
    logic             w_commit, w_err_inc;
    logic             r_s_tready, w_s_tready_nxt, r_m_tvalid;
    logic             w_s_fire, w_m_fire, w_rd_en, w_ram_we;
    logic [RW-1:0]    w_rd_word;

    assign w_s_fire  = s_tvalid & r_s_tready;
    assign w_m_fire  = r_m_tvalid & m_tready;
    assign w_exp_cur = (r_state == IDLE) ? exp_len : r_exp_len;
    assign w_cnt1    = (r_state == IDLE) ? LEN_W'(1) : r_beat_cnt + LEN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr_ptr;
        w_cm_nxt    = r_cm_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_commit    = 1'b0;
        w_err_inc   = 1'b0;
        if (w_s_fire) begin
            case (r_state)
                IDLE, RECV: begin
                    w_wr_nxt    = r_wr_ptr + AW'(1);
                    w_beat_nxt  = w_cnt1;
                    w_state_nxt = RECV;
                    if (s_tlast) begin
                        w_state_nxt = IDLE;
                        if (w_exp_cur == '0 || w_cnt1 == w_exp_cur) begin
                            w_commit = 1'b1;
                            w_cm_nxt = r_wr_ptr + AW'(1);
                        end else begin
                            w_err_inc = 1'b1;
                            w_wr_nxt  = r_cm_ptr;
                        end
                    end else if (w_cnt1 == LEN_W'(MAX_LEN)) begin
                        // Over-length: roll back now and swallow the rest.
                        w_err_inc   = 1'b1;
                        w_wr_nxt    = r_cm_ptr;
                        w_state_nxt = DROP;
                    end
                end
                DROP: begin
                    if (s_tlast) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // rd_ptr frees a slot only when the word leaves the output register.
    assign w_rd_en        = (r_cm_ptr != r_ra_ptr) && (!r_m_tvalid || m_tready);
    assign w_rd_nxt       = r_rd_ptr + AW'(w_m_fire);
    assign w_s_tready_nxt = (w_state_nxt == DROP) || ((w_wr_nxt - w_rd_nxt) != AW'(DEPTH));
    assign w_ram_we       = w_s_fire && (r_state != DROP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ra_ptr   <= '0;
            r_beat_cnt <= '0;
            r_exp_len  <= '0;
            r_ok_cnt   <= '0;
            r_err_cnt  <= '0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_cm_ptr   <= w_cm_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_s_tready <= w_s_tready_nxt;
            if (w_rd_en) r_ra_ptr <= r_ra_ptr + AW'(1);
            if (w_rd_en)       r_m_tvalid <= 1'b1;
            else if (m_tready) r_m_tvalid <= 1'b0;
            if (r_state == IDLE && w_s_fire) r_exp_len <= exp_len;
            if (w_commit)  r_ok_cnt  <= r_ok_cnt + CNT_W'(1);
            if (w_err_inc) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    sdp_ram #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr[AW-2:0]),
        .i_wdata ({s_tlast, s_tdata}),
        .i_re    (w_rd_en),
        .i_raddr (r_ra_ptr[AW-2:0]),
        .o_rdata (w_rd_word)
    );

`ifdef AXIS_FRAME_RX_TUSER_EN
    logic [USER_W-1:0] r_umem [DEPTH];
    logic [USER_W-1:0] r_user, r_m_tuser, w_first_user;
    logic [AW-1:0]     r_uw, r_ua, w_ua_eff;

    assign w_first_user = (r_state == IDLE) ? s_tuser : r_user;
    // Advance past a frame's entry in the same cycle its last word is taken.
    assign w_ua_eff     = r_ua + AW'(w_m_fire && m_tlast);

    always_ff @(posedge clk) begin
        if (w_commit) r_umem[r_uw[AW-2:0]] <= w_first_user;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_user    <= '0;
            r_m_tuser <= '0;
            r_uw      <= '0;
            r_ua      <= '0;
        end else begin
            if (r_state == IDLE && w_s_fire) r_user <= s_tuser;
            if (w_commit) r_uw <= r_uw + AW'(1);
            r_ua <= w_ua_eff;
            if (w_rd_en) r_m_tuser <= r_umem[w_ua_eff[AW-2:0]];
        end
    end

    assign m_tuser = r_m_tuser;
`else
    logic w_unused_tuser;
    assign w_unused_tuser = ^s_tuser;
    assign m_tuser        = '0;
`endif

    assign s_tready      = r_s_tready;
    assign m_tvalid      = r_m_tvalid;
    assign m_tdata       = w_rd_word[DATA_W-1:0];
    assign m_tlast       = w_rd_word[DATA_W];
    assign frame_ok_cnt  = r_ok_cnt;
    assign frame_err_cnt = r_err_cnt;
    assign dbg_state     = r_state;

endmodule
